btn_debounce_multi: RTL and testbench

BTN_DEBOUNCE_MULTI -- requirements
Module: btn_debounce_multi

---
 rtl/btn_debounce_multi.sv | 116 +++++++++++
 tb/tb_btn_debounce_multi.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_multi.sv
// rtl/btn_debounce_multi.sv - multi-channel button debouncer with press/release/long-press pulses and LED drive
module btn_debounce_multi #(
  parameter int N_CH        = 4,
  parameter int DB_CYCLES   = 1000000,
  parameter int LONG_CYCLES = 100000000
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic [N_CH-1:0] i_btn,
  input  logic [N_CH-1:0] i_mode,
  output logic [N_CH-1:0] o_stable,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic [N_CH-1:0] o_long,
  output logic [N_CH-1:0] o_led
);

  localparam int DB_W   = $clog2(DB_CYCLES);
  localparam int LONG_W = $clog2(LONG_CYCLES);

  // Terminal counts; both counters stop here rather than wrapping.
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              stable_q, stable_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
    logic              long_done_q, long_done_d;
    logic              long_q, long_d;
    logic              led_q, led_d;

    // Synchronizer, debounce acceptance, long-press timing and LED update.
    always_comb begin
      sync1_d     = i_btn[g];
      sync2_d     = sync1_q;

      stable_d    = stable_q;
      db_cnt_d    = db_cnt_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      if (sync2_q == stable_q) begin
        // Input agrees with the accepted level: any partial count is a glitch.
        db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
        stable_d  = sync2_q;
        db_cnt_d  = '0;
        press_d   = sync2_q;
        release_d = ~sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end

      long_cnt_d  = long_cnt_q;
      long_done_d = long_done_q;
      long_d      = 1'b0;
      if (press_d) begin
        long_cnt_d  = '0;
        long_done_d = 1'b0;
      end else if (stable_q && !long_done_q) begin
        // The done flag makes the long pulse one-shot and parks the counter.
        if (long_cnt_q == LONG_LAST) begin
          long_d      = 1'b1;
          long_done_d = 1'b1;
        end else begin
          long_cnt_d = long_cnt_q + LONG_W'(1);
        end
      end

      // Momentary mirrors the next debounced level; toggle flips on accepted press.
      if (i_mode[g]) begin
        led_d = stable_d;
      end else begin
        led_d = led_q ^ press_d;
      end
    end

    // Per-channel state registers, cleared asynchronously.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        sync1_q     <= 1'b0;
        sync2_q     <= 1'b0;
        db_cnt_q    <= '0;
        stable_q    <= 1'b0;
        press_q     <= 1'b0;
        release_q   <= 1'b0;
        long_cnt_q  <= '0;
        long_done_q <= 1'b0;
        long_q      <= 1'b0;
        led_q       <= 1'b0;
      end else begin
        sync1_q     <= sync1_d;
        sync2_q     <= sync2_d;
        db_cnt_q    <= db_cnt_d;
        stable_q    <= stable_d;
        press_q     <= press_d;
        release_q   <= release_d;
        long_cnt_q  <= long_cnt_d;
        long_done_q <= long_done_d;
        long_q      <= long_d;
        led_q       <= led_d;
      end
    end

    assign o_stable[g]  = stable_q;
    assign o_press[g]   = press_q;
    assign o_release[g] = release_q;
    assign o_long[g]    = long_q;
    assign o_led[g]     = led_q;
  end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// tb/tb_btn_debounce_multi.sv - scoreboard bench for btn_debounce_multi
module tb_btn_debounce_multi;

  localparam int N_CH = 4;
  localparam int DB   = 4;
  localparam int LONG = 10;
  localparam int LAT  = 2 + DB;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_LONG  = 2;

  typedef struct {
    int cyc;
    int kind;
    int ch;
  } ev_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N_CH-1:0] btn;
  logic [N_CH-1:0] mode;
  logic [N_CH-1:0] o_stable, o_press, o_release, o_long, o_led;

  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  ev_t  sb[$];

  btn_debounce_multi #(
    .N_CH(N_CH), .DB_CYCLES(DB), .LONG_CYCLES(LONG)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_btn(btn), .i_mode(mode),
    .o_stable(o_stable), .o_press(o_press), .o_release(o_release),
    .o_long(o_long), .o_led(o_led)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic pulse_of(input int k, input int ch);
    case (k)
      K_PRESS: return o_press[ch];
      K_REL:   return o_release[ch];
      default: return o_long[ch];
    endcase
  endfunction

  function automatic string kname(input int k);
    case (k)
      K_PRESS: return "press";
      K_REL:   return "release";
      default: return "long";
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int ch, input int at);
    ev_t e;
    e.cyc = at; e.kind = kind; e.ch = ch;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive a new clean button level; optionally schedule the resulting edge pulses.
  task automatic set_btn(input logic [N_CH-1:0] v, input bit do_push);
    for (int ch = 0; ch < N_CH; ch++) begin
      if (do_push && (v[ch] !== btn[ch])) push(v[ch] ? K_PRESS : K_REL, ch, cyc + LAT);
    end
    btn = v;
  endtask

  // Scoreboard: every observed pulse must match a scheduled one; overdue entries are misses.
  always @(negedge clk) begin
    for (int ch = 0; ch < N_CH; ch++) begin
      for (int k = 0; k < 3; k++) begin
        if (pulse_of(k, ch) === 1'b1) begin
          int idx;
          idx = -1;
          for (int i = 0; i < sb.size(); i++)
            if (sb[i].cyc == cyc && sb[i].kind == k && sb[i].ch == ch) idx = i;
          n_assert++;
          assert (idx >= 0) else begin
            n_fail++;
            $error("FAIL sb_%s ch%0d: pulse observed at cycle %0d, required none", kname(k), ch, cyc);
          end
          if (idx >= 0) sb.delete(idx);
        end
      end
    end
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        n_assert++;
        assert (pulse_of(sb[i].kind, sb[i].ch) === 1'b1) else begin
          n_fail++;
          $error("FAIL sb_%s ch%0d: observed 0 at cycle %0d, required pulse at cycle %0d",
                 kname(sb[i].kind), sb[i].ch, cyc, sb[i].cyc);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int e;
    rst_n = 1'b0;
    btn   = '0;
    mode  = 4'b0100;
    wait_cyc(3);
    chk("reset_outputs", {o_stable, o_press, o_release, o_long, o_led}, 0);
    rst_n = 1'b1;
    wait_cyc(3);
    chk("idle_outputs", {o_stable, o_press, o_release, o_long, o_led}, 0);

    // Clean press ch0 in toggle mode, then a second press/release.
    e = cyc;
    set_btn(4'b0001, 1'b1);
    wait_cyc(LAT - 1);
    chk("ch0_stable_before", o_stable[0], 0);
    chk("ch0_led_before", o_led[0], 0);
    wait_cyc(1);
    chk("ch0_stable_at_lat", o_stable[0], 1);
    chk("ch0_press_at_lat", o_press[0], 1);
    chk("ch0_led_on", o_led[0], 1);
    wait_cyc(1);
    chk("ch0_press_one_cycle", o_press[0], 0);
    set_btn(4'b0000, 1'b1);
    wait_cyc(LAT + 1);
    chk("ch0_stable_released", o_stable[0], 0);
    chk("ch0_led_hold_on_release", o_led[0], 1);
    set_btn(4'b0001, 1'b1);
    wait_cyc(LAT);
    chk("ch0_led_off_second", o_led[0], 0);
    wait_cyc(1);
    set_btn(4'b0000, 1'b1);
    wait_cyc(LAT + 2);

    // Bounce on ch1: high 3, low 1, then steady high.
    btn[1] = 1'b1;
    wait_cyc(3);
    btn[1] = 1'b0;
    wait_cyc(1);
    set_btn(4'b0010, 1'b1);
    wait_cyc(LAT - 1);
    chk("ch1_no_early_accept", o_stable[1], 0);
    wait_cyc(1);
    chk("ch1_press_after_bounce", o_press[1], 1);
    wait_cyc(1);
    set_btn(4'b0000, 1'b1);
    wait_cyc(LAT + 2);
    chk("ch1_led_toggled", o_led[1], 1);

    // Momentary ch2 held 20 cycles: long pulse 10 cycles after press.
    e = cyc;
    set_btn(4'b0100, 1'b1);
    push(K_LONG, 2, e + LAT + LONG);
    wait_cyc(LAT);
    chk("ch2_led_follows_on", o_led[2], 1);
    wait_cyc(20 - LAT);
    set_btn(4'b0000, 1'b1);
    wait_cyc(LAT - 1);
    chk("ch2_led_still_on", o_led[2], 1);
    wait_cyc(1);
    chk("ch2_led_follows_off", o_led[2], 0);
    wait_cyc(LONG + 2);

    // Short press ch3: released 8 cycles after press, no long pulse.
    set_btn(4'b1000, 1'b1);
    wait_cyc(8);
    set_btn(4'b0000, 1'b1);
    wait_cyc(LAT + LONG);

    // All four channels pressed together.
    set_btn(4'b1111, 1'b1);
    wait_cyc(LAT);
    chk("all_press", o_press, 4'b1111);
    chk("all_led", o_led, 4'b0101);
    wait_cyc(1);
    set_btn(4'b0000, 1'b1);
    wait_cyc(LAT + 2);
    chk("all_released_led", o_led, 4'b0001);

    // Mode switch ch0: toggle->momentary with led on and button low.
    mode[0] = 1'b1;
    #1;
    chk("mode_sw_same_cycle", o_led[0], 1);
    wait_cyc(1);
    chk("mode_sw_led_follows", o_led[0], 0);
    set_btn(4'b0001, 1'b1);
    wait_cyc(LAT);
    chk("mom_ch0_led_on", o_led[0], 1);
    wait_cyc(1);
    mode[0] = 1'b0;
    set_btn(4'b0000, 1'b1);
    wait_cyc(LAT + 1);
    chk("toggle_back_led_holds", o_led[0], 1);
    set_btn(4'b0001, 1'b1);
    wait_cyc(LAT);
    chk("toggle_back_press_flips", o_led[0], 0);
    wait_cyc(1);
    set_btn(4'b0000, 1'b1);
    wait_cyc(LAT + 2);

    // Reset mid long-count on ch1 and mid-debounce on ch0.
    set_btn(4'b0010, 1'b1);
    wait_cyc(LAT);
    btn[0] = 1'b1;
    wait_cyc(3);
    chk("pre_reset_stable", o_stable, 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {o_stable, o_press, o_release, o_long, o_led}, 0);
    wait_cyc(3);
    chk("held_reset_outputs", {o_stable, o_press, o_release, o_long, o_led}, 0);
    rst_n = 1'b1;
    push(K_PRESS, 0, cyc + LAT);
    push(K_PRESS, 1, cyc + LAT);
    wait_cyc(LAT - 1);
    chk("post_reset_not_yet", o_stable, 0);
    wait_cyc(1);
    chk("post_reset_press", o_press, 4'b0011);
    wait_cyc(1);
    set_btn(4'b0000, 1'b1);
    wait_cyc(LAT + LONG);

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
